// File: rtl/lc3_wb_pkg.sv
// Shared types and defaults for the LC-3 register-file write-back arbiter.
package lc3_wb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NREG_DEF   = 8;

    typedef logic [2:0] reg_idx_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_t;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin arbiter between the ALU and MEM write-back requests.
module wb_rr_arb2
    import lc3_wb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    wb_src_t prio;

    always_comb begin
        gnt_alu = req_alu && (!req_mem || (prio == WB_ALU));
        gnt_mem = req_mem && (!req_alu || (prio == WB_MEM));
    end

    // Priority moves only when both sides compete; a lone requester never disturbs it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= WB_ALU;
        end else if (req_alu && req_mem) begin
            prio <= (prio == WB_ALU) ? WB_MEM : WB_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and MEM write-backs into one register-file write port and tracks
// per-register pending reservations with saturating 2-bit counters.
module regfile_wb_arbiter
    import lc3_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  reg_idx_t          alu_dr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  reg_idx_t          mem_dr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              rsv_valid,
    input  reg_idx_t          rsv_dr,
    output logic [NREG-1:0]   reg_ld,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [NREG-1:0]   busy,
    output logic              rsv_err
);

    logic              gnt_alu;
    logic              gnt_mem;
    logic              xfer;
    reg_idx_t          xfer_dr;
    logic [DATA_W-1:0] xfer_data;
    logic [NREG-1:0]   inc_vec;
    logic [NREG-1:0]   dec_vec;
    logic              sat_hit;
    logic [1:0]        cnt [NREG];

    wb_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_alu (alu_valid),
        .req_mem (mem_valid),
        .gnt_alu (gnt_alu),
        .gnt_mem (gnt_mem)
    );

    // Ready is held low while reset is asserted so nothing is accepted into a clearing pipeline.
    always_comb begin
        alu_ready = gnt_alu && rst_n;
        mem_ready = gnt_mem && rst_n;
        xfer      = alu_ready || mem_ready;
        xfer_dr   = alu_ready ? alu_dr : mem_dr;
        xfer_data = alu_ready ? alu_data : mem_data;
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        sat_hit = 1'b0;
        if (rsv_valid) inc_vec[rsv_dr] = 1'b1;
        if (xfer)      dec_vec[xfer_dr] = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            if (inc_vec[i] && !dec_vec[i] && (cnt[i] == 2'd3)) sat_hit = 1'b1;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NREG; i++) busy[i] = (cnt[i] != 2'd0);
    end

    // A simultaneous reserve and retire on one register cancel out, even at the limits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= 2'd0;
            rsv_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (inc_vec[i] && !dec_vec[i] && (cnt[i] != 2'd3)) begin
                    cnt[i] <= cnt[i] + 2'd1;
                end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != 2'd0)) begin
                    cnt[i] <= cnt[i] - 2'd1;
                end
            end
            if (sat_hit) rsv_err <= 1'b1;
        end
    end

    // dec_vec is already the one-hot of the accepted destination, or zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_ld    <= '0;
            reg_wdata <= '0;
        end else begin
            reg_ld <= dec_vec;
            if (xfer) reg_wdata <= xfer_data;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, shall set the write-data width.
REQ-002 Parameter NREG, default 8, shall set the register count; the index width is 3 bits.
REQ-003 Clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  shall be the asynchronous, active-low reset.
REQ-005 alu_valid/alu_dr/alu_data  input  1/3/DATA_W  shall carry the ALU write-back request.
REQ-006 alu_ready  output  1  shall indicate that the ALU request is accepted this cycle.
REQ-007 mem_valid/mem_dr/mem_data  input  1/3/DATA_W  shall carry the memory-load write-back request.
REQ-008 mem_ready  output  1  shall indicate that the MEM request is accepted this cycle.
REQ-009 rsv_valid/rsv_dr  input  1/3  shall reserve a destination register at instruction issue.
REQ-010 reg_ld  output  NREG  shall drive the one-hot register-file load enables.
REQ-011 reg_wdata  output  DATA_W  shall drive the register-file write data.
REQ-012 busy  output  NREG  shall flag registers with pending reservations.
REQ-013 rsv_err  output  1  shall be a sticky flag for reservation overflow.

Function
REQ-014 A transfer shall occur on a requester when valid and ready are both high at a rising edge.
REQ-015 The block shall accept at most one transfer per cycle.
REQ-016 Readiness:
- A lone valid requester shall get ready=1.
- An invalid requester shall get ready=0.
- Ready may depend combinationally on both valids.
REQ-017 When both requesters are valid, the grant shall go to the requester holding round-robin priority.
REQ-018 The priority pointer shall toggle to the other requester only on a contested grant.
REQ-019 An uncontested grant shall leave the priority pointer unchanged.
REQ-020 On a transfer, the next cycle shall show:
- reg_ld = one-hot(dr), for exactly one cycle.
- reg_wdata = the accepted data.
This is a fixed 1-cycle latency.
REQ-021 In cycles with no transfer in the previous cycle:
- reg_ld shall be all-zero.
- reg_wdata shall hold its last value.
REQ-022 Each register shall have a 2-bit pending counter; busy[i] shall equal (count[i] != 0).
REQ-023 rsv_valid shall increment count[rsv_dr] at the edge it is sampled.
REQ-024 A transfer shall decrement count[dr] at the same edge that loads reg_ld.
REQ-025 When an increment and a decrement hit the same register on the same edge, its count shall remain unchanged.
REQ-026 An increment at count 3 shall be dropped and shall set rsv_err, which stays set until reset.
REQ-027 A decrement at count 0 shall be ignored and the write shall still proceed.
REQ-028 When requesters target the same dr in consecutive cycles, both writes shall be issued in grant order; there shall be no merging.
REQ-029 A requester whose valid drops before being granted shall be discarded without side effects.

Reset
REQ-030 Assertion of Reset_n=0 shall asynchronously force:
- reg_ld=0, reg_wdata=0, busy=0;
- all counters to 0;
- rsv_err=0;
- priority to ALU.
REQ-031 While reset is asserted, alu_ready and mem_ready shall be 0.
REQ-032 A write registered but not yet presented when reset asserts shall be dropped.
REQ-033 Operation shall resume on the first rising edge after Reset_n deasserts.

Structure
REQ-034 Package lc3_wb_pkg shall hold:
- DATA_W and NREG defaults;
- typedef reg_idx_t (3 bits);
- enum wb_src_t {WB_ALU, WB_MEM}.
REQ-035 The two-way round-robin grant logic shall be the sub-module wb_rr_arb2 (inputs: two requests; outputs: two grants; internal priority flop).
REQ-036 Counters and output registers shall reside in regfile_wb_arbiter.

Verification
REQ-037 Single ALU write, dr=5, data=16'h1234 -> alu_ready=1; the next cycle shows reg_ld=8'b0010_0000 and reg_wdata=16'h1234, with reg_ld=0 after.
REQ-038 Both requesters valid for 4 cycles after reset (ALU dr=1, MEM dr=2) -> grants ALU, MEM, ALU, MEM; reg_ld=02,04,02,04 with 1-cycle lag.
REQ-039 Reserve dr=3 twice, then one ALU write to dr=3 -> busy[3] stays 1; a second write makes busy[3]=0 the same cycle its reg_ld pulses.
REQ-040 rsv_dr=6 four times -> count saturates at 3 and rsv_err=1; three writes to r6 clear busy[6], and rsv_err remains 1.
REQ-041 Same-edge rsv_valid (dr=4) and MEM write (dr=4) at count 1 -> busy[4] stays 1 and the count stays 1.
REQ-042 Reset_n pulsed low between acceptance and presentation of a write to r7 -> reg_ld never shows 8'h80, busy=0, and priority returns to ALU.
